oq_buffer_trader: RTL and testbench

- Parametrised successor to the output-queue event-capture/buffer-sizing plugin.
- Tracks per-queue packet and word occupancy from the output-queue store/remove strobes.
- Scans queues round-robin and classifies each queue into one of NUM_LEVELS buffer levels using software-programmable thresholds with hysteresis.
- When a queue's level changes, issues a valid/ack update of that queue's buffer allocation to the register block, then emits a level-change event for the event recorder.

---
 rtl/oq_buffer_trader_pkg.sv | 34 +++
 rtl/oq_buffer_trader_if.sv | 29 ++
 rtl/oq_level_eval.sv | 40 ++++
 rtl/oq_buffer_trader.sv | 237 +++++++++++++++++++++++
 tb/tb_oq_buffer_trader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oq_buffer_trader_pkg.sv
// Shared types, width helpers and error-flag indices for the output-queue buffer trader.
package oq_buffer_trader_pkg;

    localparam int unsigned LevelWidth = 3;

    localparam int unsigned ErrUnderflow = 0;
    localparam int unsigned ErrOverflow  = 1;
    localparam int unsigned ErrTimeout   = 2;

    typedef enum logic [1:0] {
        StScan,
        StEval,
        StReq
    } state_e;

    // Ceiling log2, minimum 1 so single-entry selects keep a legal width.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_words_width(input int unsigned sram_addr_width);
        return sram_addr_width;
    endfunction

    function automatic int unsigned max_num_pkts_width(input int unsigned sram_addr_width);
        return sram_addr_width - 3;
    endfunction

endpackage

// File: rtl/oq_buffer_trader_if.sv
// Allocation-update handshake towards the register block plus level-change event strobe.
interface oq_buffer_trader_if
    import oq_buffer_trader_pkg::*;
#(
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned SRAM_ADDR_WIDTH   = 19
);
    localparam int unsigned OqWidth    = log2(NUM_OUTPUT_QUEUES);
    localparam int unsigned WordsWidth = max_words_width(SRAM_ADDR_WIDTH);

    logic                  upd_valid;
    logic [OqWidth-1:0]    upd_oq;
    logic [WordsWidth-1:0] upd_value;
    logic                  upd_ack;
    logic                  evt_valid;
    logic [OqWidth-1:0]    evt_oq;
    logic [LevelWidth-1:0] evt_level;

    modport master (
        output upd_valid, upd_oq, upd_value, evt_valid, evt_oq, evt_level,
        input  upd_ack
    );

    modport slave (
        input  upd_valid, upd_oq, upd_value, evt_valid, evt_oq, evt_level,
        output upd_ack
    );

endinterface

// File: rtl/oq_level_eval.sv
// Threshold priority encoder with hysteresis on downward level moves.
module oq_level_eval
    import oq_buffer_trader_pkg::*;
#(
    parameter int unsigned NUM_LEVELS  = 6,
    parameter int unsigned WORDS_WIDTH = 19
) (
    input  logic [WORDS_WIDTH-1:0]                occ,
    input  logic [LevelWidth-1:0]                 cur,
    input  logic [(NUM_LEVELS-1)*WORDS_WIDTH-1:0] thresh,
    input  logic [WORDS_WIDTH-1:0]                hyst,
    output logic [LevelWidth-1:0]                 new_level
);

    logic [LevelWidth-1:0]  raw;
    logic [WORDS_WIDTH-1:0] th_below;
    logic [WORDS_WIDTH:0]   occ_hyst;

    always_comb begin
        raw = '0;
        for (int k = 0; k < NUM_LEVELS - 1; k++) begin
            if (occ > thresh[k*WORDS_WIDTH +: WORDS_WIDTH]) raw = raw + LevelWidth'(1);
        end

        // Threshold directly below the current level, the one we must clear by hyst.
        th_below = '0;
        for (int k = 0; k < NUM_LEVELS - 1; k++) begin
            if (LevelWidth'(k + 1) == cur) th_below = thresh[k*WORDS_WIDTH +: WORDS_WIDTH];
        end

        occ_hyst  = {1'b0, occ} + {1'b0, hyst};
        new_level = cur;
        if (raw > cur) begin
            new_level = raw;
        end else if (raw < cur && occ_hyst <= {1'b0, th_below}) begin
            new_level = raw;
        end
    end

endmodule

// File: rtl/oq_buffer_trader.sv
// Per-queue occupancy counters and a round-robin scanner that re-sizes queue buffers
// through a valid/ack update and reports each level change as an event.
module oq_buffer_trader
    import oq_buffer_trader_pkg::*;
#(
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned NUM_LEVELS        = 6,
    parameter int unsigned PKT_WORDS_WIDTH   = 8,
    parameter int unsigned SRAM_ADDR_WIDTH   = 19,
    parameter int unsigned ACK_TIMEOUT       = 1024,
    localparam int unsigned OqWidth          = log2(NUM_OUTPUT_QUEUES),
    localparam int unsigned MAX_WORDS_WIDTH  = max_words_width(SRAM_ADDR_WIDTH),
    localparam int unsigned MAX_NUM_PKTS_WIDTH = max_num_pkts_width(SRAM_ADDR_WIDTH)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    pkt_stored,
    input  logic [PKT_WORDS_WIDTH-1:0]              stored_words,
    input  logic [OqWidth-1:0]                      dst_oq,
    input  logic                                    pkt_removed,
    input  logic [PKT_WORDS_WIDTH-1:0]              removed_words,
    input  logic [OqWidth-1:0]                      removed_oq,
    input  logic                                    enable,
    input  logic [MAX_WORDS_WIDTH-1:0]              hyst_words,
    input  logic [(NUM_LEVELS-1)*MAX_WORDS_WIDTH-1:0] lvl_thresh,
    input  logic [NUM_LEVELS*MAX_WORDS_WIDTH-1:0]   lvl_alloc,
    output logic [64*NUM_OUTPUT_QUEUES-1:0]         oq_abs_regs,
    oq_buffer_trader_if.master                      upd_bus,
    output logic [2:0]                              err_flags
);

    localparam int unsigned Mw        = MAX_WORDS_WIDTH;
    localparam int unsigned Mp        = MAX_NUM_PKTS_WIDTH;
    localparam int unsigned WaitWidth = $clog2(ACK_TIMEOUT) + 1;

    logic [Mw-1:0] num_words_q [NUM_OUTPUT_QUEUES];
    logic [Mw-1:0] num_words_d [NUM_OUTPUT_QUEUES];
    logic [Mp-1:0] num_pkts_q  [NUM_OUTPUT_QUEUES];
    logic [Mp-1:0] num_pkts_d  [NUM_OUTPUT_QUEUES];
    logic [NUM_OUTPUT_QUEUES-1:0] uflow, oflow;
    logic          store_hit, rem_hit;
    logic [Mw:0]   add_words, sub_words, sum_words;

    logic [2:0] err_q;
    logic       timeout_set;

    always_comb begin
        uflow     = '0;
        oflow     = '0;
        store_hit = 1'b0;
        rem_hit   = 1'b0;
        add_words = '0;
        sub_words = '0;
        sum_words = '0;
        for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) begin
            num_words_d[q] = num_words_q[q];
            num_pkts_d[q]  = num_pkts_q[q];
            store_hit      = pkt_stored && (dst_oq == OqWidth'(q));
            rem_hit        = pkt_removed && (removed_oq == OqWidth'(q));
            add_words      = store_hit ? (Mw+1)'(stored_words) : '0;
            sub_words      = rem_hit ? (Mw+1)'(removed_words) : '0;
            sum_words      = {1'b0, num_words_q[q]} + add_words;
            if (sum_words < sub_words) begin
                num_words_d[q] = '0;
                uflow[q]       = 1'b1;
            end else if ((sum_words - sub_words) > {1'b0, {Mw{1'b1}}}) begin
                num_words_d[q] = '1;
                oflow[q]       = 1'b1;
            end else begin
                num_words_d[q] = Mw'(sum_words - sub_words);
            end
            // A store and a removal on the same queue leave the packet count alone.
            if (store_hit && !rem_hit) begin
                if (&num_pkts_q[q]) oflow[q] = 1'b1;
                else                num_pkts_d[q] = num_pkts_q[q] + Mp'(1);
            end else if (rem_hit && !store_hit) begin
                if (num_pkts_q[q] == '0) uflow[q] = 1'b1;
                else                     num_pkts_d[q] = num_pkts_q[q] - Mp'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) begin
                num_words_q[q] <= '0;
                num_pkts_q[q]  <= '0;
            end
            err_q <= '0;
        end else begin
            for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) begin
                num_words_q[q] <= num_words_d[q];
                num_pkts_q[q]  <= num_pkts_d[q];
            end
            err_q[ErrUnderflow] <= err_q[ErrUnderflow] | (|uflow);
            err_q[ErrOverflow]  <= err_q[ErrOverflow] | (|oflow);
            err_q[ErrTimeout]   <= err_q[ErrTimeout] | timeout_set;
        end
    end

    always_comb begin
        oq_abs_regs = '0;
        for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) begin
            oq_abs_regs[64*q +: 64] = {32'(num_pkts_q[q]), 32'(num_words_q[q])};
        end
    end

    assign err_flags = err_q;

    // Scanner / update FSM.
    state_e                 state_q, state_d;
    logic [OqWidth-1:0]     scan_ptr_q, scan_ptr_d;
    logic [OqWidth-1:0]     ptr_q, ptr_d;
    logic [Mw-1:0]          occ_q, occ_d;
    logic [OqWidth-1:0]     upd_oq_q, upd_oq_d;
    logic [Mw-1:0]          upd_value_q, upd_value_d;
    logic [LevelWidth-1:0]  lvl_n_q, lvl_n_d;
    logic [WaitWidth-1:0]   wait_q, wait_d;
    logic                   evt_valid_q, evt_valid_d;
    logic [OqWidth-1:0]     evt_oq_q, evt_oq_d;
    logic [LevelWidth-1:0]  evt_level_q, evt_level_d;
    logic [LevelWidth-1:0]  cur_level_q [NUM_OUTPUT_QUEUES];
    logic                   cur_wr;
    logic [LevelWidth-1:0]  new_level;
    logic [Mw-1:0]          alloc_sel;

    oq_level_eval #(
        .NUM_LEVELS  (NUM_LEVELS),
        .WORDS_WIDTH (Mw)
    ) u_level_eval (
        .occ       (occ_q),
        .cur       (cur_level_q[ptr_q]),
        .thresh    (lvl_thresh),
        .hyst      (hyst_words),
        .new_level (new_level)
    );

    always_comb begin
        alloc_sel = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (new_level == LevelWidth'(k)) alloc_sel = lvl_alloc[k*Mw +: Mw];
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_ptr_d  = scan_ptr_q;
        ptr_d       = ptr_q;
        occ_d       = occ_q;
        upd_oq_d    = upd_oq_q;
        upd_value_d = upd_value_q;
        lvl_n_d     = lvl_n_q;
        wait_d      = wait_q;
        evt_valid_d = 1'b0;
        evt_oq_d    = evt_oq_q;
        evt_level_d = evt_level_q;
        cur_wr      = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            StScan: begin
                if (enable) begin
                    occ_d   = num_words_q[scan_ptr_q];
                    ptr_d   = scan_ptr_q;
                    state_d = StEval;
                end
            end
            StEval: begin
                if (new_level == cur_level_q[ptr_q]) begin
                    scan_ptr_d = scan_ptr_q + OqWidth'(1);
                    state_d    = StScan;
                end else begin
                    upd_oq_d    = ptr_q;
                    upd_value_d = alloc_sel;
                    lvl_n_d     = new_level;
                    wait_d      = '0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (upd_bus.upd_ack) begin
                    cur_wr      = 1'b1;
                    evt_valid_d = 1'b1;
                    evt_oq_d    = upd_oq_q;
                    evt_level_d = lvl_n_q;
                    scan_ptr_d  = scan_ptr_q + OqWidth'(1);
                    state_d     = StScan;
                end else if (wait_q == WaitWidth'(ACK_TIMEOUT - 1)) begin
                    // Abandon; the unchanged cur_level makes the next scan retry it.
                    timeout_set = 1'b1;
                    scan_ptr_d  = scan_ptr_q + OqWidth'(1);
                    state_d     = StScan;
                end else begin
                    wait_d = wait_q + WaitWidth'(1);
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StScan;
            scan_ptr_q  <= '0;
            ptr_q       <= '0;
            occ_q       <= '0;
            upd_oq_q    <= '0;
            upd_value_q <= '0;
            lvl_n_q     <= '0;
            wait_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_oq_q    <= '0;
            evt_level_q <= '0;
            for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) cur_level_q[q] <= '0;
        end else begin
            state_q     <= state_d;
            scan_ptr_q  <= scan_ptr_d;
            ptr_q       <= ptr_d;
            occ_q       <= occ_d;
            upd_oq_q    <= upd_oq_d;
            upd_value_q <= upd_value_d;
            lvl_n_q     <= lvl_n_d;
            wait_q      <= wait_d;
            evt_valid_q <= evt_valid_d;
            evt_oq_q    <= evt_oq_d;
            evt_level_q <= evt_level_d;
            if (cur_wr) cur_level_q[ptr_q] <= lvl_n_q;
        end
    end

    assign upd_bus.upd_valid = (state_q == StReq);
    assign upd_bus.upd_oq    = upd_oq_q;
    assign upd_bus.upd_value = upd_value_q;
    assign upd_bus.evt_valid = evt_valid_q;
    assign upd_bus.evt_oq    = evt_oq_q;
    assign upd_bus.evt_level = evt_level_q;

endmodule

// File: tb/tb_oq_buffer_trader.sv
// Directed bench: counters, threshold updates, hysteresis, ack timeout and saturation.
module tb_oq_buffer_trader;

    localparam int unsigned Noq = 8;
    localparam int unsigned Nl  = 6;
    localparam int unsigned Pw  = 8;
    localparam int unsigned Saw = 19;
    localparam int unsigned At  = 16;
    localparam int unsigned Mw  = 19;

    logic               clk = 1'b0;
    logic               reset;
    logic               pkt_stored, pkt_removed, enable;
    logic [Pw-1:0]      stored_words, removed_words;
    logic [2:0]         dst_oq, removed_oq;
    logic [Mw-1:0]      hyst_words;
    logic [(Nl-1)*Mw-1:0] lvl_thresh;
    logic [Nl*Mw-1:0]   lvl_alloc;
    logic [64*Noq-1:0]  oq_abs_regs;
    logic [2:0]         err_flags;

    int checks   = 0;
    int failures = 0;

    oq_buffer_trader_if #(
        .NUM_OUTPUT_QUEUES (Noq),
        .SRAM_ADDR_WIDTH   (Saw)
    ) bus ();

    oq_buffer_trader #(
        .NUM_OUTPUT_QUEUES (Noq),
        .NUM_LEVELS        (Nl),
        .PKT_WORDS_WIDTH   (Pw),
        .SRAM_ADDR_WIDTH   (Saw),
        .ACK_TIMEOUT       (At)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_stored    (pkt_stored),
        .stored_words  (stored_words),
        .dst_oq        (dst_oq),
        .pkt_removed   (pkt_removed),
        .removed_words (removed_words),
        .removed_oq    (removed_oq),
        .enable        (enable),
        .hyst_words    (hyst_words),
        .lvl_thresh    (lvl_thresh),
        .lvl_alloc     (lvl_alloc),
        .oq_abs_regs   (oq_abs_regs),
        .upd_bus       (bus),
        .err_flags     (err_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input int q, input int w);
        pkt_stored   = 1'b1;
        dst_oq       = 3'(q);
        stored_words = 8'(w);
        tick();
        pkt_stored   = 1'b0;
    endtask

    task automatic remove(input int q, input int w);
        pkt_removed   = 1'b1;
        removed_oq    = 3'(q);
        removed_words = 8'(w);
        tick();
        pkt_removed   = 1'b0;
    endtask

    task automatic wait_upd(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            if (bus.upd_valid === 1'b1) found = 1'b1;
            else tick();
        end
    endtask

    task automatic ack_upd();
        bus.upd_ack = 1'b1;
        tick();
        bus.upd_ack = 1'b0;
    endtask

    function automatic logic [63:0] words_of(input int q);
        return 64'(oq_abs_regs[64*q +: 32]);
    endfunction

    function automatic logic [63:0] pkts_of(input int q);
        return 64'(oq_abs_regs[64*q+32 +: 32]);
    endfunction

    initial begin
        bit found;
        bit seen;
        int hi;

        reset         = 1'b1;
        pkt_stored    = 1'b0;
        pkt_removed   = 1'b0;
        stored_words  = '0;
        removed_words = '0;
        dst_oq        = '0;
        removed_oq    = '0;
        enable        = 1'b0;
        hyst_words    = 19'd200;
        lvl_thresh    = {19'd47616, 19'd29696, 19'd11776, 19'd6553, 19'd1638};
        lvl_alloc     = {19'd400000, 19'd300000, 19'd200000, 19'd100000, 19'd57344, 19'd8192};
        bus.upd_ack   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset_upd_valid", 64'(bus.upd_valid), 0);
        check("reset_upd_oq", 64'(bus.upd_oq), 0);
        check("reset_upd_value", 64'(bus.upd_value), 0);
        check("reset_evt_valid", 64'(bus.evt_valid), 0);
        check("reset_evt_oq", 64'(bus.evt_oq), 0);
        check("reset_evt_level", 64'(bus.evt_level), 0);
        check("reset_err_flags", 64'(err_flags), 0);
        check("reset_oq_abs_nonzero", 64'(|oq_abs_regs), 0);

        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            seen |= (bus.upd_valid === 1'b1);
            tick();
        end
        check("idle_no_upd", 64'(seen), 0);

        // Same-queue store+remove, then stores/removes on different queues.
        store(5, 40);
        check("q5_store_words", words_of(5), 40);
        pkt_stored   = 1'b1; dst_oq = 3'd5; stored_words = 8'd40;
        pkt_removed  = 1'b1; removed_oq = 3'd5; removed_words = 8'd24;
        tick();
        pkt_stored   = 1'b0; pkt_removed = 1'b0;
        check("same_q_words", words_of(5), 56);
        check("same_q_pkts", pkts_of(5), 1);
        pkt_stored   = 1'b1; dst_oq = 3'd1; stored_words = 8'd20;
        pkt_removed  = 1'b1; removed_oq = 3'd5; removed_words = 8'd6;
        tick();
        pkt_stored   = 1'b0; pkt_removed = 1'b0;
        check("diff_q1_words", words_of(1), 20);
        check("diff_q1_pkts", pkts_of(1), 1);
        check("diff_q5_words", words_of(5), 50);
        check("diff_q5_pkts", pkts_of(5), 0);
        check("diff_err_clear", 64'(err_flags), 0);

        remove(2, 10);
        check("uflow_words", words_of(2), 0);
        check("uflow_pkts", pkts_of(2), 0);
        check("uflow_err", 64'(err_flags), 3'b001);

        bus.upd_ack = 1'b1;
        tick();
        bus.upd_ack = 1'b0;
        check("stray_ack_no_evt", 64'(bus.evt_valid), 0);

        // Climb queue 3 to level 1.
        for (int i = 0; i < 30; i++) store(3, 64);
        check("q3_words", words_of(3), 1920);
        check("q3_regs", {pkts_of(3)[31:0], words_of(3)[31:0]}, {32'd30, 32'd1920});
        wait_upd(60, found);
        check("up_seen", 64'(found), 1);
        check("up_oq", 64'(bus.upd_oq), 3);
        check("up_value", 64'(bus.upd_value), 57344);
        ack_upd();
        check("up_evt_valid", 64'(bus.evt_valid), 1);
        check("up_evt_oq", 64'(bus.evt_oq), 3);
        check("up_evt_level", 64'(bus.evt_level), 1);
        check("up_valid_drop", 64'(bus.upd_valid), 0);
        tick();
        check("up_evt_pulse", 64'(bus.evt_valid), 0);

        // Hysteresis: 1500+200 > 1638 holds level 1; 1400+200 <= 1638 releases it.
        for (int i = 0; i < 4; i++) remove(3, 55);
        check("q3_at_1700", words_of(3), 1700);
        for (int i = 0; i < 4; i++) remove(3, 50);
        check("q3_at_1500", words_of(3), 1500);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= (bus.upd_valid === 1'b1);
            tick();
        end
        check("hyst_hold", 64'(seen), 0);
        for (int i = 0; i < 2; i++) remove(3, 50);
        check("q3_at_1400", words_of(3), 1400);
        wait_upd(60, found);
        check("down_seen", 64'(found), 1);
        check("down_oq", 64'(bus.upd_oq), 3);
        check("down_value", 64'(bus.upd_value), 8192);
        ack_upd();
        check("down_evt_valid", 64'(bus.evt_valid), 1);
        check("down_evt_level", 64'(bus.evt_level), 0);

        // Ack timeout on queue 6, then retry on a later scan.
        for (int i = 0; i < 26; i++) store(6, 64);
        wait_upd(60, found);
        check("to_seen", 64'(found), 1);
        check("to_oq", 64'(bus.upd_oq), 6);
        hi = 0;
        while (bus.upd_valid === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        check("to_valid_cycles", 64'(hi), At);
        check("to_err", 64'(err_flags), 3'b101);
        check("to_no_evt", 64'(bus.evt_valid), 0);
        wait_upd(60, found);
        check("retry_seen", 64'(found), 1);
        check("retry_oq", 64'(bus.upd_oq), 6);
        check("retry_value", 64'(bus.upd_value), 57344);
        ack_upd();
        check("retry_evt_oq", 64'(bus.evt_oq), 6);
        check("retry_evt_level", 64'(bus.evt_level), 1);

        // Saturate queue 7's word counter: 2060*255 exceeds 2^19-1.
        enable = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2060; i++) store(7, 255);
        check("oflow_words", words_of(7), 524287);
        check("oflow_pkts", pkts_of(7), 2060);
        check("oflow_err", 64'(err_flags), 3'b111);
        check("disabled_no_upd", 64'(bus.upd_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
